// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state, register offsets and STATUS layout for mmio_uart_tx
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [2:0] TXDATA_OFF = 3'd0;
    localparam logic [2:0] STATUS_OFF = 3'd4;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 4;

    // Occupancy field is only four bits wide, so larger FIFOs report 15
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO that accepts a push while full if a pop frees a slot that cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next pointers, occupancy and storage contents
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (push_ok) mem_d[wr_ptr_q] = wdata;
    end

    // Pointer and count registers cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and pollable status
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  MemWriteByte,
    output logic        Sel,
    output logic [31:0] ReadData,
    output logic        tx
);

    localparam int          BW       = $clog2(CLKS_PER_BIT);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          push_req;
    logic          ovf_clr;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign Sel      = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign push_req = MemWrite && Sel && (DataAdr[2] == TXDATA_OFF[2]) && MemWriteByte[0];
    assign ovf_clr  = MemWrite && Sel && (DataAdr[2] == STATUS_OFF[2]) && MemWriteByte[0] && WriteData[3];
    assign tx       = tx_q;
    assign unused_bits = ^{DataAdr[1:0], WriteData[31:8], MemWriteByte[3:1]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (WriteData[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: a dropped byte sets it, W1C clears it, set beats clear
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    end

    // STATUS word and read mux; TXDATA reads as zero
    always_comb begin
        status                 = '0;
        status[STAT_FULL_BIT]  = fifo_full;
        status[STAT_EMPTY_BIT] = fifo_empty;
        status[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
        status[STAT_OVF_BIT]   = ovf_q;
        status[STAT_CNT_LSB +: 4] = sat_count(32'(fifo_count));
        ReadData = (Sel && DataAdr[2] == STATUS_OFF[2]) ? status : '0;
    end

    // Frame sequencer: baud countdown, bit index, shift register and FIFO pop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = BAUD_MAX;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    state_d = ST_DATA;
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        baud_d  = BAUD_MAX;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tx_d = (state_d == ST_START) ? 1'b0 : (state_d == ST_DATA) ? shift_d[0] : 1'b1;
    end

    // Registered state; reset aborts any frame in flight and idles the line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench decoding tx frames against the bytes stored
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          CPB  = 4;
    localparam int          DEP  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [3:0]  MemWriteByte = '0;
    logic        Sel;
    logic [31:0] ReadData;
    logic        tx;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          exp_start = -1;
    int          gap_n = 0;
    int          last_start = -1;
    logic        mon_act = 1'b0;
    int          mon_ph = 0;
    logic [7:0]  mon_byte = '0;
    logic [31:0] rd;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .MemWriteByte (MemWriteByte),
        .Sel          (Sel),
        .ReadData     (ReadData),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] be);
        MemWrite     = 1'b1;
        DataAdr      = adr;
        WriteData    = dat;
        MemWriteByte = be;
        step(1);
        MemWrite     = 1'b0;
        MemWriteByte = '0;
        DataAdr      = '0;
        WriteData    = '0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        DataAdr = BASE + 32'd4;
        #1;
        v = ReadData;
        DataAdr = '0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || mon_act) && n < max) begin
            step(1);
            n++;
        end
        check("drain_in_budget", 32'(n < max), 32'd1);
    endtask

    // Line monitor: mid-bit sampling of each frame, compared against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_ph  = 0;
                if (exp_start >= 0) begin
                    check("start_latency", 32'(cyc), 32'(exp_start));
                    exp_start = -1;
                end else if (gap_n > 0) begin
                    check("frame_gap", 32'(cyc - last_start), 32'(10 * CPB));
                    gap_n--;
                end
                last_start = cyc;
            end
        end else begin
            mon_ph++;
            if (mon_ph == CPB / 2) check("start_bit", 32'(tx), 32'd0);
            if (mon_ph >= CPB + CPB / 2 && mon_ph <= 8 * CPB + CPB / 2 && (mon_ph - CPB / 2) % CPB == 0)
                mon_byte[(mon_ph - CPB - CPB / 2) / CPB] = tx;
            if (mon_ph == 9 * CPB + CPB / 2) begin
                check("stop_bit", 32'(tx), 32'd1);
                if (exp_q.size() == 0) check("unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                else check("frame_data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
            end
            if (mon_ph == 10 * CPB - 1) mon_act = 1'b0;
        end
    end

    initial begin
        int c;
        step(3);
        reset = 1'b0;

        step(50);
        check("idle_tx", 32'(tx), 32'd1);
        rd_status(rd);
        check("idle_status", rd, 32'h2);

        c = cyc;
        exp_start = c + 2;
        exp_q.push_back(8'hA5);
        store(BASE, 32'h0000_00A5, 4'b0001);
        rd_status(rd);
        check("one_byte_status", rd, 32'h10);
        step(40);
        rd_status(rd);
        check("busy_last_stop", rd, 32'h6);
        step(1);
        rd_status(rd);
        check("busy_cleared", rd, 32'h2);

        exp_start = cyc + 2;
        gap_n = 2;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        store(BASE, 32'h11, 4'b0001);
        store(BASE, 32'h22, 4'b0001);
        store(BASE, 32'h33, 4'b0001);
        rd_status(rd);
        check("three_store_status", rd, 32'h24);
        drain(300);
        rd_status(rd);
        check("after_three_status", rd, 32'h2);

        exp_start = cyc + 2;
        gap_n = 9;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'h40 + 8'(i));
            store(BASE, 32'h40 + 32'(i), 4'b0001);
        end
        rd_status(rd);
        check("burst_full_ovf", rd, 32'h8D);
        step(31);
        exp_q.push_back(8'h4A);
        store(BASE, 32'h4A, 4'b0001);
        rd_status(rd);
        check("push_with_pop_full", rd, 32'h8D);
        store(BASE + 32'd4, 32'h8, 4'b0001);
        rd_status(rd);
        check("ovf_w1c", rd, 32'h85);
        drain(700);
        rd_status(rd);
        check("after_burst_status", rd, 32'h2);

        store(BASE, 32'h0000_7700, 4'b0010);
        rd_status(rd);
        check("lane1_no_push", rd, 32'h2);
        DataAdr = BASE + 32'd8;
        #1;
        check("sel_base8", 32'(Sel), 32'd0);
        store(BASE + 32'd8, 32'h66, 4'b0001);
        rd_status(rd);
        check("base8_no_push", rd, 32'h2);
        DataAdr = BASE + 32'd4;
        #1;
        check("sel_base4", 32'(Sel), 32'd1);
        DataAdr = BASE;
        #1;
        check("txdata_reads_zero", ReadData, 32'h0);
        DataAdr = '0;
        step(60);
        check("negatives_no_frame", 32'(exp_q.size()) | 32'(mon_act), 32'd0);

        c = cyc;
        exp_start = c + 2;
        exp_q.push_back(8'h5A);
        store(BASE, 32'h5A, 4'b0001);
        step(18);
        reset = 1'b1;
        exp_q.delete();
        step(1);
        reset = 1'b0;
        check("reset_tx", 32'(tx), 32'd1);
        rd_status(rd);
        check("reset_status", rd, 32'h2);
        exp_start = cyc + 2;
        exp_q.push_back(8'hC3);
        store(BASE, 32'hC3, 4'b0001);
        drain(200);
        rd_status(rd);
        check("final_status", rd, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
